// File: rtl/dc_line_mover.sv
// dc_line_mover: data-cache miss engine on the 128-bit data RAM line port.
// Optionally writes the dirty victim line back as 4 x 32-bit beats, then
// fetches the new line as 4 beats and writes it into the data RAM.
// Optional feature macro: DC_LINE_MOVER_TIMEOUT_EN (idle-beat watchdog with err pulse).
//
// state   | meaning
// IDLE    | ready for a miss request
// WB_RD   | read victim line from data RAM
// WB_CAP  | capture RAM read data into line buffer
// WB_CMD  | issue write-burst command for victim
// WB_DATA | send victim line as 4 write beats
// FL_CMD  | issue read-burst command for fill line
// FL_DATA | collect 4 read beats into line buffer
// FL_WR   | write assembled line into data RAM
// DONE    | pulse fill_done
module dc_line_mover #(
    parameter int DWIDTH    = 11,
    parameter int TO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [DWIDTH-3:0] req_line_idx,
    input  logic [27:0]       req_victim_adr,
    input  logic [27:0]       req_fill_adr,
    output logic [DWIDTH-3:0] ram_radr_all,
    output logic              ram_ren_all,
    input  logic [127:0]      ram_rdata_all,
    output logic [DWIDTH-3:0] ram_wadr_all,
    output logic [127:0]      ram_wdata_all,
    output logic              ram_wen_all,
    output logic              ext_cmd_valid,
    input  logic              ext_cmd_ready,
    output logic              ext_cmd_we,
    output logic [27:0]       ext_cmd_adr,
    output logic              ext_wvalid,
    input  logic              ext_wready,
    output logic [31:0]       ext_wdata,
    input  logic              ext_rvalid,
    input  logic [31:0]       ext_rdata,
    output logic              busy,
    output logic              fill_done,
    output logic              err
);

    typedef enum logic [3:0] {
        IDLE, WB_RD, WB_CAP, WB_CMD, WB_DATA, FL_CMD, FL_DATA, FL_WR, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-3:0] idx_q, idx_d;
    logic [27:0]       vadr_q, vadr_d;
    logic [27:0]       fadr_q, fadr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [127:0]      line_q, line_d;
    logic              timeout;

`ifdef DC_LINE_MOVER_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       waiting;
    logic       beat_acc;

    // Watchdog runs only while waiting on the external bus
    always_comb begin
        waiting  = (state_q == WB_CMD) || (state_q == WB_DATA) ||
                   (state_q == FL_CMD) || (state_q == FL_DATA);
        timeout  = waiting && (wd_q == 8'(TO_CYCLES));
        beat_acc = ((state_q == WB_DATA) && ext_wready) ||
                   ((state_q == FL_DATA) && ext_rvalid);
        wd_d     = 8'd0;
        if (waiting && !beat_acc && (state_d == state_q))
            wd_d = wd_q + 8'd1;
    end

    // Watchdog register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_q <= 8'd0;
        else     wd_q <= wd_d;
    end

    assign err = timeout;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // Next-state, request capture, beat counter and line buffer assembly
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vadr_d  = vadr_q;
        fadr_d  = fadr_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d   = req_line_idx;
                    vadr_d  = req_victim_adr;
                    fadr_d  = req_fill_adr;
                    state_d = req_wb ? WB_RD : FL_CMD;
                end
            end
            WB_RD:  state_d = WB_CAP;
            WB_CAP: begin
                line_d  = ram_rdata_all;
                state_d = WB_CMD;
            end
            WB_CMD: if (ext_cmd_ready) state_d = WB_DATA;
            WB_DATA: begin
                if (ext_wready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = FL_CMD;
                end
            end
            FL_CMD: if (ext_cmd_ready) state_d = FL_DATA;
            FL_DATA: begin
                if (ext_rvalid) begin
                    line_d[{cnt_q, 5'b0} +: 32] = ext_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = FL_WR;
                end
            end
            FL_WR:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort leaves the buffer untouched; it is never written to RAM
        if (timeout) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            line_d  = line_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vadr_q  <= '0;
            fadr_q  <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vadr_q  <= vadr_d;
            fadr_q  <= fadr_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    // Outputs decoded from state; address/data buses are zero when unused
    always_comb begin
        req_ready     = (state_q == IDLE);
        busy          = (state_q != IDLE);
        ram_ren_all   = (state_q == WB_RD);
        ram_radr_all  = (state_q == WB_RD) ? idx_q : '0;
        ram_wen_all   = (state_q == FL_WR);
        ram_wadr_all  = (state_q == FL_WR) ? idx_q : '0;
        ram_wdata_all = (state_q == FL_WR) ? line_q : '0;
        ext_cmd_valid = ((state_q == WB_CMD) || (state_q == FL_CMD)) && !timeout;
        ext_cmd_we    = (state_q == WB_CMD) && !timeout;
        ext_cmd_adr   = '0;
        if (state_q == WB_CMD) ext_cmd_adr = vadr_q;
        if (state_q == FL_CMD) ext_cmd_adr = fadr_q;
        ext_wvalid    = (state_q == WB_DATA) && !timeout;
        ext_wdata     = (state_q == WB_DATA) ? line_q[{cnt_q, 5'b0} +: 32] : '0;
        fill_done     = (state_q == DONE);
    end

endmodule

// File: tb/tb_dc_line_mover.sv
// Self-checking bench for dc_line_mover: a sampling recorder logs every bus
// event, scenario tasks push expected events and compare them in order.
module tb_dc_line_mover;

    localparam int DW = 11;
    localparam int IW = DW - 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wb;
    logic [IW-1:0] req_line_idx;
    logic [27:0]   req_victim_adr, req_fill_adr;
    logic [IW-1:0] ram_radr_all, ram_wadr_all;
    logic          ram_ren_all, ram_wen_all;
    logic [127:0]  ram_rdata_all, ram_wdata_all;
    logic          ext_cmd_valid, ext_cmd_ready, ext_cmd_we;
    logic [27:0]   ext_cmd_adr;
    logic          ext_wvalid, ext_wready;
    logic [31:0]   ext_wdata;
    logic          ext_rvalid;
    logic [31:0]   ext_rdata;
    logic          busy, fill_done, err;

    dc_line_mover #(.DWIDTH(DW), .TO_CYCLES(255)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_line_idx(req_line_idx), .req_victim_adr(req_victim_adr),
        .req_fill_adr(req_fill_adr),
        .ram_radr_all(ram_radr_all), .ram_ren_all(ram_ren_all),
        .ram_rdata_all(ram_rdata_all), .ram_wadr_all(ram_wadr_all),
        .ram_wdata_all(ram_wdata_all), .ram_wen_all(ram_wen_all),
        .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready),
        .ext_cmd_we(ext_cmd_we), .ext_cmd_adr(ext_cmd_adr),
        .ext_wvalid(ext_wvalid), .ext_wready(ext_wready), .ext_wdata(ext_wdata),
        .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .busy(busy), .fill_done(fill_done), .err(err)
    );

    always #5 clk = ~clk;

    // Event encoding: tag 0 = command {we,adr}, 1 = write beat, 2 = RAM line write {idx,data}
    function automatic logic [138:0] ev_cmd(input logic we, input logic [27:0] a);
        return {2'd0, 108'd0, we, a};
    endfunction
    function automatic logic [138:0] ev_beat(input logic [31:0] d);
        return {2'd1, 105'd0, d};
    endfunction
    function automatic logic [138:0] ev_ramw(input logic [IW-1:0] i, input logic [127:0] d);
        return {2'd2, i, d};
    endfunction

    // Recorder: samples on the falling edge, never drives DUT inputs
    logic [138:0] obs_ev[$];
    int           cyc = 0, acc_cyc = 0, done_cyc = 0, err_cyc = 0;
    int           ren_cnt = 0, both_cnt = 0, hold_viol = 0, ready_viol = 0;
    int           acc_cnt = 0, done_cnt = 0;
    logic         p_cmd_stall = 1'b0, p_w_stall = 1'b0;
    logic [28:0]  p_cmd = '0;
    logic [31:0]  p_wd = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (ext_cmd_valid && ext_cmd_ready) obs_ev.push_back(ev_cmd(ext_cmd_we, ext_cmd_adr));
            if (ext_wvalid && ext_wready)       obs_ev.push_back(ev_beat(ext_wdata));
            if (ram_wen_all)                    obs_ev.push_back(ev_ramw(ram_wadr_all, ram_wdata_all));
            if (ram_ren_all)                    ren_cnt <= ren_cnt + 1;
            if (ram_ren_all && ram_wen_all)     both_cnt <= both_cnt + 1;
            if (busy == req_ready)              ready_viol <= ready_viol + 1;
            if ((p_cmd_stall && !(ext_cmd_valid && {ext_cmd_we, ext_cmd_adr} == p_cmd)) ||
                (p_w_stall && !(ext_wvalid && ext_wdata == p_wd)))
                hold_viol <= hold_viol + 1;
            p_cmd_stall <= ext_cmd_valid && !ext_cmd_ready;
            p_cmd       <= {ext_cmd_we, ext_cmd_adr};
            p_w_stall   <= ext_wvalid && !ext_wready;
            p_wd        <= ext_wdata;
            if (req_valid && req_ready) begin acc_cyc <= cyc; acc_cnt <= acc_cnt + 1; end
            if (fill_done) begin done_cyc <= cyc; done_cnt <= done_cnt + 1; end
            if (err) err_cyc <= cyc;
        end else begin
            p_cmd_stall <= 1'b0;
            p_w_stall   <= 1'b0;
        end
    end

    logic [138:0] exp_ev[$];
    int           rd_ev = 0;
    int           n_checks = 0, n_fail = 0;

    // Drives one miss and acts as external bus and data RAM until fill_done.
    // abort_beats > 0 asserts rst after that many fill beats have been accepted.
    task automatic run_miss(input logic wb, input logic [IW-1:0] idx,
                            input logic [27:0] vadr, input logic [27:0] fadr,
                            input logic [127:0] vline, input logic [127:0] fline,
                            input int cmd_wait, input bit wtoggle, input bit stray,
                            input int abort_beats, output bit finished);
        int            wait_cnt = 0, rbeat = 0, budget = 0;
        bit            fill_go = 1'b0;
        logic          s_cmdv, s_cmdrdy, s_cmdwe, s_ren, s_done, s_wv;
        logic [IW-1:0] s_radr;
        if (wb) begin
            exp_ev.push_back(ev_cmd(1'b1, vadr));
            for (int i = 0; i < 4; i++) exp_ev.push_back(ev_beat(vline[32*i +: 32]));
        end
        exp_ev.push_back(ev_cmd(1'b0, fadr));
        if (abort_beats == 0) exp_ev.push_back(ev_ramw(idx, fline));
        finished = 1'b0;
        @(posedge clk); #1;
        req_valid      = 1'b1;
        req_wb         = wb;
        req_line_idx   = idx;
        req_victim_adr = vadr;
        req_fill_adr   = fadr;
        ext_cmd_ready  = (cmd_wait == 0);
        ext_wready     = 1'b1;
        while (budget < 300) begin
            @(negedge clk);
            s_cmdv = ext_cmd_valid; s_cmdrdy = ext_cmd_ready; s_cmdwe = ext_cmd_we;
            s_ren = ram_ren_all; s_radr = ram_radr_all; s_done = fill_done; s_wv = ext_wvalid;
            @(posedge clk); #1;
            budget++;
            if (s_done) begin
                finished = 1'b1; req_valid = 1'b0; ext_rvalid = 1'b0;
                break;
            end
            if (stray) begin
                req_wb         = 1'($urandom);
                req_line_idx   = IW'($urandom);
                req_victim_adr = 28'($urandom);
                req_fill_adr   = 28'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            ram_rdata_all = (s_ren && s_radr == idx) ? vline
                                                     : {$urandom, $urandom, $urandom, $urandom};
            if (s_cmdv && s_cmdrdy) begin
                wait_cnt = 0;
                if (!s_cmdwe) fill_go = 1'b1;
            end else if (s_cmdv) begin
                wait_cnt++;
            end
            ext_cmd_ready = (wait_cnt >= cmd_wait);
            ext_wready    = wtoggle ? ~ext_wready : 1'b1;
            if (fill_go && rbeat < 4) begin
                if (abort_beats != 0 && rbeat == abort_beats) begin
                    ext_rvalid = 1'b0; req_valid = 1'b0; rst = 1'b1; #1;
                    return;
                end
                ext_rvalid = 1'b1;
                ext_rdata  = fline[32*rbeat +: 32];
                rbeat++;
            end else begin
                ext_rvalid = stray && s_wv;
                ext_rdata  = $urandom;
            end
        end
        ext_rvalid = 1'b0;
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 0; req_wb = 0; req_line_idx = '0; req_victim_adr = '0; req_fill_adr = '0;
        ram_rdata_all = '0; ext_cmd_ready = 0; ext_wready = 0; ext_rvalid = 0; ext_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        n_checks++;
        if ({busy, ram_ren_all, ram_wen_all, ext_cmd_valid, ext_cmd_we, ext_wvalid, fill_done, err} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, ram_ren_all, ram_wen_all, ext_cmd_valid, ext_cmd_we, ext_wvalid, fill_done, err});
        end
        n_checks++;
        if ({ram_radr_all, ram_wadr_all, ram_wdata_all, ext_cmd_adr, ext_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: got %h want 0",
                     {ram_radr_all, ram_wadr_all, ram_wdata_all, ext_cmd_adr, ext_wdata});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_clean();
        bit fin;
        int r0 = ren_cnt;
        logic [138:0] ev;
        run_miss(1'b0, 9'd5, 28'h0, 28'h0000123, '0,
                 128'h44444444_33333333_22222222_11111111, 0, 1'b0, 1'b0, 0, fin);
        @(negedge clk);
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL clean_done: got timeout want fill_done"); end
        n_checks++;
        if (done_cyc - acc_cyc != 7) begin
            n_fail++; $display("FAIL clean_latency: got %0d want 7", done_cyc - acc_cyc);
        end
        n_checks++;
        if (ren_cnt != r0) begin n_fail++; $display("FAIL clean_no_ren: got %0d want 0", ren_cnt - r0); end
        while (exp_ev.size() > 0) begin
            ev = exp_ev.pop_front(); n_checks++;
            if (rd_ev >= obs_ev.size()) begin
                n_fail++; $display("FAIL clean_event: got none want %h", ev);
            end else begin
                if (obs_ev[rd_ev] !== ev) begin
                    n_fail++; $display("FAIL clean_event: got %h want %h", obs_ev[rd_ev], ev);
                end
                rd_ev++;
            end
        end
        n_checks++;
        if (obs_ev.size() != rd_ev) begin
            n_fail++; $display("FAIL clean_extra: got %0d events want %0d", obs_ev.size(), rd_ev);
            rd_ev = obs_ev.size();
        end
    endtask

    task automatic test_dirty(input string name, input int cmd_wait, input bit wtoggle, input bit stray);
        bit fin;
        int r0 = ren_cnt, h0 = hold_viol, a0 = acc_cnt;
        logic [138:0] ev;
        if (stray) begin
            ext_rvalid = 1'b1; ext_rdata = 32'hBAD0BAD0;
            repeat (2) @(posedge clk);
            #1 ext_rvalid = 1'b0;
        end
        run_miss(1'b1, 9'd5, 28'hABCDEF1, 28'h0000123,
                 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF,
                 128'h44444444_33333333_22222222_11111111, cmd_wait, wtoggle, stray, 0, fin);
        @(negedge clk);
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL %s_done: got timeout want fill_done", name); end
        n_checks++;
        if (ren_cnt - r0 != 1) begin
            n_fail++; $display("FAIL %s_ren_cycles: got %0d want 1", name, ren_cnt - r0);
        end
        n_checks++;
        if (hold_viol != h0) begin
            n_fail++; $display("FAIL %s_hold: got %0d violations want 0", name, hold_viol - h0);
        end
        n_checks++;
        if (acc_cnt - a0 != 1) begin
            n_fail++; $display("FAIL %s_accepts: got %0d want 1", name, acc_cnt - a0);
        end
        while (exp_ev.size() > 0) begin
            ev = exp_ev.pop_front(); n_checks++;
            if (rd_ev >= obs_ev.size()) begin
                n_fail++; $display("FAIL %s_event: got none want %h", name, ev);
            end else begin
                if (obs_ev[rd_ev] !== ev) begin
                    n_fail++; $display("FAIL %s_event: got %h want %h", name, obs_ev[rd_ev], ev);
                end
                rd_ev++;
            end
        end
        n_checks++;
        if (obs_ev.size() != rd_ev) begin
            n_fail++; $display("FAIL %s_extra: got %0d events want %0d", name, obs_ev.size(), rd_ev);
            rd_ev = obs_ev.size();
        end
    endtask

    task automatic test_reset_mid();
        bit fin;
        int d0;
        logic [138:0] ev;
        run_miss(1'b0, 9'd7, 28'h0, 28'h0000456, '0,
                 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 0, 1'b0, 1'b0, 2, fin);
        n_checks++;
        if (fin || rst !== 1'b1) begin n_fail++; $display("FAIL rstmid_abort: got fin=%b rst=%b want 0 1", fin, rst); end
        n_checks++;
        if ({req_ready, busy, ram_wen_all, ext_cmd_valid, ext_wvalid, fill_done} !== 6'b100000) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %b want 100000",
                     {req_ready, busy, ram_wen_all, ext_cmd_valid, ext_wvalid, fill_done});
        end
        d0 = 0;
        repeat (3) begin
            @(negedge clk);
            if (ram_wen_all) d0++;
        end
        n_checks++;
        if (d0 != 0) begin n_fail++; $display("FAIL rstmid_wen: got %0d cycles want 0", d0); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got busy=%b want 0", busy); end
        while (exp_ev.size() > 0) begin
            ev = exp_ev.pop_front(); n_checks++;
            if (rd_ev >= obs_ev.size()) begin
                n_fail++; $display("FAIL rstmid_event: got none want %h", ev);
            end else begin
                if (obs_ev[rd_ev] !== ev) begin
                    n_fail++; $display("FAIL rstmid_event: got %h want %h", obs_ev[rd_ev], ev);
                end
                rd_ev++;
            end
        end
        n_checks++;
        if (obs_ev.size() != rd_ev) begin
            n_fail++; $display("FAIL rstmid_extra: got %0d events want %0d", obs_ev.size(), rd_ev);
            rd_ev = obs_ev.size();
        end
    endtask

`ifdef DC_LINE_MOVER_TIMEOUT_EN
    task automatic test_timeout();
        int budget = 0;
        int n0 = obs_ev.size();
        @(posedge clk); #1;
        req_valid = 1'b1; req_wb = 1'b0; req_line_idx = 9'd3; req_fill_adr = 28'h0000789;
        ext_cmd_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        while (!err && budget < 400) begin @(negedge clk); budget++; end
        n_checks++;
        if (!err) begin
            n_fail++; $display("FAIL timeout_err: got no err want pulse");
        end else begin
            n_checks++;
            if (err_cyc + 1 - acc_cyc != 256) begin
                n_fail++; $display("FAIL timeout_delay: got %0d want 256", err_cyc + 1 - acc_cyc);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({busy, err, ext_cmd_valid} !== 3'b000 || obs_ev.size() != n0) begin
            n_fail++; $display("FAIL timeout_idle: got busy/err/valid=%b events=%0d want 000 0",
                               {busy, err, ext_cmd_valid}, obs_ev.size() - n0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean();
        test_dirty("dirty", 0, 1'b0, 1'b0);
        test_dirty("backpressure", 3, 1'b1, 1'b0);
        test_dirty("stray", 0, 1'b0, 1'b1);
        test_reset_mid();
        test_clean();
`ifdef DC_LINE_MOVER_TIMEOUT_EN
        test_timeout();
`endif
        @(negedge clk);
        n_checks++;
        if (both_cnt != 0) begin n_fail++; $display("FAIL ren_wen_overlap: got %0d want 0", both_cnt); end
        n_checks++;
        if (ready_viol != 0) begin n_fail++; $display("FAIL busy_vs_ready: got %0d want 0", ready_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
